// File: rtl/sdp_fifo_pkg.sv
// Shared helpers for the SDP stream FIFO: occupancy width and a legality check for DEPTH.
// Combinational functions only, with no latency or backpressure of their own.
package sdp_fifo_pkg;

   // Occupancy runs 0..DEPTH+1 because the read register holds one extra word.
   function automatic int level_width(input int depth);
      return $clog2(depth + 2);
   endfunction

   function automatic bit depth_is_valid(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/simple_dual_one_clock.sv
// Single-clock simple dual-port RAM: one write port and one registered read port, with no reset.
// Read data appears one cycle after ren_i; rdata_o holds while ren_i is low, so there is no backpressure.
module simple_dual_one_clock #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              wen_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              ren_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (wen_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (ren_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sdp_stream_fifo.sv
// Valid/ready FWFT FIFO built on an SDP RAM. Capacity is DEPTH+1 words, and latency from push to out_valid_o is 2 cycles.
// in_ready_o depends on registered state only; SDP_FIFO_LEVEL_EN adds the registered occupancy output level_o.
module sdp_stream_fifo
   import sdp_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
`ifdef SDP_FIFO_LEVEL_EN
   ,
   output logic [level_width(DEPTH)-1:0] level_o
`endif
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic              push;
   logic              pop_ram;

   assign in_ready_o  = (ram_cnt_q != CNT_FULL);
   assign push        = in_valid_i & in_ready_o;
   // A read only issues when ram_cnt_q > 0, so it never targets this cycle's write address.
   assign pop_ram     = (ram_cnt_q != '0) & (~out_valid_q | out_ready_i);
   assign out_valid_o = out_valid_q;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      ram_cnt_d   = ram_cnt_q;
      out_valid_d = out_valid_q;
      if (push) begin
         wptr_d = wptr_q + ADDR_W'(1);
      end
      if (pop_ram) begin
         rptr_d = rptr_q + ADDR_W'(1);
      end
      case ({push, pop_ram})
         2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
         2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
         default: ram_cnt_d = ram_cnt_q;
      endcase
      if (pop_ram) begin
         out_valid_d = 1'b1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_cnt_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_cnt_q   <= ram_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef SDP_FIFO_LEVEL_EN
   localparam int LVL_W = level_width(DEPTH);

   logic [LVL_W-1:0] level_q, level_d;

   assign level_d = LVL_W'(ram_cnt_d) + LVL_W'(out_valid_d);
   assign level_o = level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      assert (depth_is_valid(DEPTH));
      assert (ram_cnt_q <= CNT_FULL);
   end

   simple_dual_one_clock #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wen_i   (push),
      .waddr_i (wptr_q),
      .wdata_i (in_data_i),
      .ren_i   (pop_ram),
      .raddr_i (rptr_q),
      .rdata_o (out_data_o)
   );

endmodule
